ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection.
- Captures the decoded instruction from ID each cycle and presents srcA, srcB and the 3-bit ALU function code to the ALU.
- Drives the ID-stage stall and inserts bubbles on load-use hazards and branch flushes.
- Sits directly upstream of the ALU; its outputs feed the ALU combinationally.

---
 rtl/ex_operand_stage_pkg.sv | 24 ++
 rtl/ex_operand_stage_if.sv | 78 +++++++
 rtl/ex_operand_stage_fwd_mux.sv | 45 ++++
 rtl/ex_operand_stage.sv | 141 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage_pkg
//   Shared definitions for the ID/EX operand stage: ALU function codes,
//   the function code loaded by a pipeline bubble, and the hard-wired
//   zero register number.
package ex_operand_stage_pkg;

  // Encodings are shared with the ALU.
  typedef enum logic [2:0] {
    ALU_AND  = 3'd0,
    ALU_OR   = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_SUB  = 3'd3,
    ALU_SLLV = 3'd4,
    ALU_SRLV = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_NOP  = 3'd7
  } alu_f_e;

  // A bubble presents AND so that the idle ALU output is deterministic.
  localparam alu_f_e BUBBLE_F = ALU_AND;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if
//   Bundles every signal of the ID/EX operand stage except clock and reset.
//   master : upstream side (ID decode, MEM/WB writeback, pipeline control)
//            drives the instruction and forwarding sources.
//   slave  : the operand stage itself, driving ALU operands, registered
//            EX control bits, the ID stall and the bubble counter.
interface ex_operand_stage_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned CNTW = 16
) ();

  // ID-stage instruction
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_rd;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [2:0]    id_alu_f;
  logic          id_alusrc;
  logic          id_regdst;
  logic          id_uses_rt;
  logic          id_regwrite;
  logic          id_memtoreg;
  logic          id_memwrite;

  // Pipeline control
  logic          ex_stall;
  logic          ex_flush;

  // Forwarding sources
  logic          mem_regwrite;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_result;
  logic          wb_regwrite;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_result;

  // EX-side outputs
  logic [DW-1:0]   srcA;
  logic [DW-1:0]   srcB;
  logic [2:0]      alu_f;
  logic [DW-1:0]   ex_wdata;
  logic [AW-1:0]   ex_waddr;
  logic            ex_valid;
  logic            ex_regwrite;
  logic            ex_memtoreg;
  logic            ex_memwrite;
  logic            stall_id;
  logic [CNTW-1:0] bubble_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_f, id_alusrc, id_regdst, id_uses_rt,
           id_regwrite, id_memtoreg, id_memwrite,
           ex_stall, ex_flush,
           mem_regwrite, mem_waddr, mem_result,
           wb_regwrite, wb_waddr, wb_result,
    input  srcA, srcB, alu_f, ex_wdata, ex_waddr,
           ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite,
           stall_id, bubble_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_f, id_alusrc, id_regdst, id_uses_rt,
           id_regwrite, id_memtoreg, id_memwrite,
           ex_stall, ex_flush,
           mem_regwrite, mem_waddr, mem_result,
           wb_regwrite, wb_waddr, wb_result,
    output srcA, srcB, alu_f, ex_wdata, ex_waddr,
           ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite,
           stall_id, bubble_cnt
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// ex_fwd_mux
//   Combinational forwarding selector for one EX source operand.
//   Priority: MEM result, then WB result, then the captured register data.
//   Register 0 is never forwarded.
//   Ports:
//     mem_regwrite_i/mem_waddr_i/mem_result_i : MEM-stage write
//     wb_regwrite_i/wb_waddr_i/wb_result_i    : WB-stage write
//     src_addr_i                              : register number read in EX
//     reg_data_i                              : register data captured at ID
//     fwd_o                                   : forwarded operand
module ex_fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          mem_regwrite_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic          wb_regwrite_i,
  input  logic [AW-1:0] wb_waddr_i,
  input  logic [DW-1:0] wb_result_i,
  input  logic [AW-1:0] src_addr_i,
  input  logic [DW-1:0] reg_data_i,
  output logic [DW-1:0] fwd_o
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite_i && (mem_waddr_i != ZERO_ADDR) && (mem_waddr_i == src_addr_i);
  assign wb_hit  = wb_regwrite_i  && (wb_waddr_i  != ZERO_ADDR) && (wb_waddr_i  == src_addr_i);

  always_comb begin
    fwd_o = reg_data_i;
    if (mem_hit) begin
      fwd_o = mem_result_i;
    end else if (wb_hit) begin
      fwd_o = wb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register with EX-side operand forwarding and load-use
//   hazard detection. Outputs feed the ALU combinationally.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : ex_operand_stage_if slave modport
//             in : ID instruction fields, ex_stall/ex_flush, MEM/WB writes
//             out: srcA/srcB/alu_f, ex_wdata/ex_waddr, ex_* control bits,
//                  stall_id, bubble_cnt
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned CNTW = 16
) (
  input logic                clk,
  input logic                rst_n,
  ex_operand_stage_if.slave  bus
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memtoreg;
    logic          memwrite;
    logic [AW-1:0] waddr;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          alusrc;
    alu_f_e        alu_f;
  } ex_reg_t;

  ex_reg_t         ex_q;
  ex_reg_t         ex_d;
  logic [CNTW-1:0] bubble_cnt_q;
  logic [CNTW-1:0] bubble_cnt_d;

  logic          load_in_ex;
  logic          hazard;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  // A load in EX whose destination is read by the ID instruction.
  assign load_in_ex = ex_q.valid && ex_q.memtoreg && (ex_q.waddr != ZERO_ADDR);
  assign hazard     = load_in_ex && bus.id_valid &&
                      ((ex_q.waddr == bus.id_rs) ||
                       (bus.id_uses_rt && (ex_q.waddr == bus.id_rt)));

  assign bus.stall_id = bus.ex_stall || (hazard && !bus.ex_flush);

  always_comb begin
    ex_d = ex_q;
    if (bus.ex_stall) begin
      ex_d = ex_q;
    end else if (bus.ex_flush || hazard) begin
      // Bubble: only the fields that can cause side effects are cleared;
      // operand fields keep their old contents.
      ex_d.valid    = 1'b0;
      ex_d.regwrite = 1'b0;
      ex_d.memtoreg = 1'b0;
      ex_d.memwrite = 1'b0;
      ex_d.waddr    = '0;
      ex_d.alu_f    = BUBBLE_F;
    end else begin
      ex_d.valid    = bus.id_valid;
      ex_d.regwrite = bus.id_valid && bus.id_regwrite;
      ex_d.memtoreg = bus.id_valid && bus.id_memtoreg;
      ex_d.memwrite = bus.id_valid && bus.id_memwrite;
      ex_d.waddr    = bus.id_regdst ? bus.id_rd : bus.id_rt;
      ex_d.rs       = bus.id_rs;
      ex_d.rt       = bus.id_rt;
      ex_d.rs_data  = bus.id_rs_data;
      ex_d.rt_data  = bus.id_rt_data;
      ex_d.imm      = bus.id_imm;
      ex_d.alusrc   = bus.id_alusrc;
      ex_d.alu_f    = alu_f_e'(bus.id_alu_f);
    end
  end

  // Only hazard bubbles are counted; a flush takes precedence and is not.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!bus.ex_stall && !bus.ex_flush && hazard && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q         <= '0;
      ex_q.alu_f   <= BUBBLE_F;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  ex_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .mem_regwrite_i (bus.mem_regwrite),
    .mem_waddr_i    (bus.mem_waddr),
    .mem_result_i   (bus.mem_result),
    .wb_regwrite_i  (bus.wb_regwrite),
    .wb_waddr_i     (bus.wb_waddr),
    .wb_result_i    (bus.wb_result),
    .src_addr_i     (ex_q.rs),
    .reg_data_i     (ex_q.rs_data),
    .fwd_o          (fwd_a)
  );

  ex_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .mem_regwrite_i (bus.mem_regwrite),
    .mem_waddr_i    (bus.mem_waddr),
    .mem_result_i   (bus.mem_result),
    .wb_regwrite_i  (bus.wb_regwrite),
    .wb_waddr_i     (bus.wb_waddr),
    .wb_result_i    (bus.wb_result),
    .src_addr_i     (ex_q.rt),
    .reg_data_i     (ex_q.rt_data),
    .fwd_o          (fwd_b)
  );

  assign bus.srcA        = fwd_a;
  assign bus.srcB        = ex_q.alusrc ? ex_q.imm : fwd_b;
  assign bus.ex_wdata    = fwd_b;
  assign bus.alu_f       = ex_q.alu_f;
  assign bus.ex_waddr    = ex_q.waddr;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_memtoreg = ex_q.memtoreg;
  assign bus.ex_memwrite = ex_q.memwrite;
  assign bus.bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage
//   Directed bench for ex_operand_stage. Bubble counter is built narrow so
//   its saturation can be reached quickly.
module tb_ex_operand_stage;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CNTW = 3;

  localparam logic [2:0] F_AND = 3'd0;
  localparam logic [2:0] F_OR  = 3'd1;
  localparam logic [2:0] F_ADD = 3'd2;
  localparam logic [2:0] F_SUB = 3'd3;
  localparam logic [2:0] F_SLT = 3'd6;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;
  int exp_cnt;

  ex_operand_stage_if #(.DW(DW), .AW(AW), .CNTW(CNTW)) bus ();

  ex_operand_stage #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(
    input logic          valid,
    input logic [2:0]    f,
    input logic [AW-1:0] rs,
    input logic [DW-1:0] rs_data,
    input logic [AW-1:0] rt,
    input logic [DW-1:0] rt_data,
    input logic [AW-1:0] rd,
    input logic [DW-1:0] imm,
    input logic          alusrc,
    input logic          regdst,
    input logic          uses_rt,
    input logic          regwrite,
    input logic          memtoreg,
    input logic          memwrite
  );
    bus.id_valid    = valid;
    bus.id_alu_f    = f;
    bus.id_rs       = rs;
    bus.id_rs_data  = rs_data;
    bus.id_rt       = rt;
    bus.id_rt_data  = rt_data;
    bus.id_rd       = rd;
    bus.id_imm      = imm;
    bus.id_alusrc   = alusrc;
    bus.id_regdst   = regdst;
    bus.id_uses_rt  = uses_rt;
    bus.id_regwrite = regwrite;
    bus.id_memtoreg = memtoreg;
    bus.id_memwrite = memwrite;
  endtask

  task automatic id_idle();
    drive_id(1'b0, F_AND, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // LW r4 <- [r0 + 8]
  task automatic drive_lw_r4();
    drive_id(1'b1, F_ADD, 5'd0, 32'h10, 5'd4, 32'h0, 5'd0, 32'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // SUB r7 <- r4 - r6, depends on r4
  task automatic drive_sub_r4();
    drive_id(1'b1, F_SUB, 5'd4, 32'h44, 5'd6, 32'h66, 5'd7, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wb_mem_off();
    bus.mem_regwrite = 1'b0;
    bus.mem_waddr    = '0;
    bus.mem_result   = '0;
    bus.wb_regwrite  = 1'b0;
    bus.wb_waddr     = '0;
    bus.wb_result    = '0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    exp_cnt      = 0;
    rst_n        = 1'b0;
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
    wb_mem_off();
    id_idle();

    // 1. reset state
    #12;
    check_eq("rst_ex_valid", bus.ex_valid, 0);
    check_eq("rst_alu_f", bus.alu_f, F_AND);
    check_eq("rst_cnt", bus.bubble_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("idle_ex_valid", bus.ex_valid, 0);
    check_eq("idle_regwrite", bus.ex_regwrite, 0);
    check_eq("idle_memtoreg", bus.ex_memtoreg, 0);
    check_eq("idle_memwrite", bus.ex_memwrite, 0);
    check_eq("idle_waddr", bus.ex_waddr, 0);
    check_eq("idle_alu_f", bus.alu_f, F_AND);
    check_eq("idle_srcA", bus.srcA, 0);
    check_eq("idle_srcB", bus.srcB, 0);
    check_eq("idle_stall", bus.stall_id, 0);
    check_eq("idle_cnt", bus.bubble_cnt, 0);

    // 2. ADD r9 <- r1 + r2, r2 forwarded from MEM
    drive_id(1'b1, F_ADD, 5'd1, 32'h5, 5'd2, 32'h7, 5'd9, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    id_idle();
    bus.mem_regwrite = 1'b1;
    bus.mem_waddr    = 5'd2;
    bus.mem_result   = 32'h100;
    #1;
    check_eq("add_srcA", bus.srcA, 32'h5);
    check_eq("add_srcB_fwd", bus.srcB, 32'h100);
    check_eq("add_wdata", bus.ex_wdata, 32'h100);
    check_eq("add_alu_f", bus.alu_f, F_ADD);
    check_eq("add_valid", bus.ex_valid, 1);
    check_eq("add_regwrite", bus.ex_regwrite, 1);
    check_eq("add_waddr_rd", bus.ex_waddr, 9);
    check_eq("add_stall", bus.stall_id, 0);
    bus.mem_regwrite = 1'b0;
    #1;
    check_eq("add_srcB_reg", bus.srcB, 32'h7);

    // 3. OR with immediate; MEM vs WB priority on rs=3
    drive_id(1'b1, F_OR, 5'd3, 32'h33, 5'd5, 32'h55, 5'd12, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_idle();
    bus.mem_regwrite = 1'b1; bus.mem_waddr = 5'd3; bus.mem_result = 32'hAA;
    bus.wb_regwrite  = 1'b1; bus.wb_waddr  = 5'd3; bus.wb_result  = 32'hBB;
    #1;
    check_eq("prio_srcA_mem", bus.srcA, 32'hAA);
    check_eq("imm_srcB", bus.srcB, 32'h1234);
    check_eq("imm_wdata", bus.ex_wdata, 32'h55);
    check_eq("or_waddr_rt", bus.ex_waddr, 5);
    check_eq("or_alu_f", bus.alu_f, F_OR);
    bus.mem_waddr = 5'd0;
    #1;
    check_eq("prio_srcA_wb", bus.srcA, 32'hBB);
    bus.wb_waddr = 5'd0;
    #1;
    check_eq("prio_srcA_reg", bus.srcA, 32'h33);
    bus.mem_waddr = 5'd3; bus.mem_regwrite = 1'b0;
    #1;
    check_eq("mem_we_gate", bus.srcA, 32'h33);
    wb_mem_off();

    // 4. load-use hazard on rs
    drive_lw_r4();
    tick();
    drive_sub_r4();
    bus.mem_regwrite = 1'b1; bus.mem_waddr = 5'd0; bus.mem_result = 32'hDEAD;
    #1;
    check_eq("lu_stall", bus.stall_id, 1);
    check_eq("r0_no_fwd", bus.srcA, 32'h10);
    check_eq("lw_srcB", bus.srcB, 32'h8);
    check_eq("lw_memtoreg", bus.ex_memtoreg, 1);
    check_eq("lw_waddr", bus.ex_waddr, 4);
    bus.mem_regwrite = 1'b0;
    tick();
    exp_cnt = 1;
    bus.mem_regwrite = 1'b1; bus.mem_waddr = 5'd4; bus.mem_result = 32'h400;
    #1;
    check_eq("bub_valid", bus.ex_valid, 0);
    check_eq("bub_regwrite", bus.ex_regwrite, 0);
    check_eq("bub_memtoreg", bus.ex_memtoreg, 0);
    check_eq("bub_waddr", bus.ex_waddr, 0);
    check_eq("bub_alu_f", bus.alu_f, F_AND);
    check_eq("bub_cnt", bus.bubble_cnt, exp_cnt);
    check_eq("bub_stall_off", bus.stall_id, 0);
    tick();
    wb_mem_off();
    bus.wb_regwrite = 1'b1; bus.wb_waddr = 5'd4; bus.wb_result = 32'h400;
    #1;
    check_eq("sub_valid", bus.ex_valid, 1);
    check_eq("sub_alu_f", bus.alu_f, F_SUB);
    check_eq("sub_srcA_wb", bus.srcA, 32'h400);
    check_eq("sub_srcB", bus.srcB, 32'h66);
    check_eq("sub_waddr", bus.ex_waddr, 7);
    check_eq("sub_cnt", bus.bubble_cnt, exp_cnt);
    wb_mem_off();

    // rt hazard depends on id_uses_rt and id_valid
    drive_lw_r4();
    tick();
    drive_id(1'b1, F_OR, 5'd1, 32'h0, 5'd4, 32'h0, 5'd8, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("rt_hazard", bus.stall_id, 1);
    bus.id_uses_rt = 1'b0;
    #1;
    check_eq("rt_unused", bus.stall_id, 0);
    bus.id_uses_rt = 1'b1;
    bus.id_valid   = 1'b0;
    #1;
    check_eq("id_invalid", bus.stall_id, 0);

    // 5. same hazard under flush: bubble, not counted
    drive_sub_r4();
    bus.ex_flush = 1'b1;
    #1;
    check_eq("flush_stall", bus.stall_id, 0);
    tick();
    bus.ex_flush = 1'b0;
    id_idle();
    #1;
    check_eq("flush_valid", bus.ex_valid, 0);
    check_eq("flush_memtoreg", bus.ex_memtoreg, 0);
    check_eq("flush_cnt", bus.bubble_cnt, exp_cnt);

    // load to r0 never hazards
    drive_id(1'b1, F_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, F_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("r0_no_hazard", bus.stall_id, 0);

    // 6. ex_stall holds EX; flush during stall applies at first free edge
    drive_id(1'b1, F_OR, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    bus.ex_stall = 1'b1;
    drive_id(1'b1, F_SLT, 5'd5, 32'h55, 5'd6, 32'h66, 5'd10, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("stall_id_ext", bus.stall_id, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.id_rs_data = i;
      if (i == 0) bus.ex_flush = 1'b1;
      #1;
      check_eq("hold_alu_f", bus.alu_f, F_OR);
      check_eq("hold_srcA", bus.srcA, 32'h11);
      check_eq("hold_valid", bus.ex_valid, 1);
      check_eq("hold_memwrite", bus.ex_memwrite, 1);
      check_eq("hold_waddr", bus.ex_waddr, 3);
      check_eq("hold_stall_id", bus.stall_id, 1);
    end
    bus.ex_stall = 1'b0;
    #1;
    check_eq("unstall_id", bus.stall_id, 0);
    tick();
    bus.ex_flush = 1'b0;
    #1;
    check_eq("sflush_valid", bus.ex_valid, 0);
    check_eq("sflush_memwrite", bus.ex_memwrite, 0);
    check_eq("sflush_alu_f", bus.alu_f, F_AND);
    check_eq("sflush_cnt", bus.bubble_cnt, exp_cnt);
    tick();
    #1;
    check_eq("slt_valid", bus.ex_valid, 1);
    check_eq("slt_alu_f", bus.alu_f, F_SLT);
    check_eq("slt_waddr", bus.ex_waddr, 10);
    check_eq("slt_srcA", bus.srcA, 32'h2);

    // stall over a hazard: counter waits for the non-stalled edge
    drive_lw_r4();
    tick();
    drive_sub_r4();
    bus.ex_stall = 1'b1;
    tick();
    check_eq("stallhz_cnt", bus.bubble_cnt, exp_cnt);
    check_eq("stallhz_memtoreg", bus.ex_memtoreg, 1);
    bus.ex_stall = 1'b0;
    #1;
    check_eq("stallhz_stall_id", bus.stall_id, 1);
    tick();
    exp_cnt = exp_cnt + 1;
    check_eq("stallhz_cnt_inc", bus.bubble_cnt, exp_cnt);

    // saturation of the bubble counter
    for (int k = 0; k < 7; k++) begin
      drive_lw_r4();
      tick();
      drive_sub_r4();
      tick();
      if (exp_cnt < 7) exp_cnt = exp_cnt + 1;
      check_eq("sat_cnt", bus.bubble_cnt, exp_cnt);
    end
    check_eq("sat_final", bus.bubble_cnt, 7);

    // reset in the middle of a hazard
    drive_lw_r4();
    tick();
    drive_sub_r4();
    #1;
    check_eq("prerst_stall", bus.stall_id, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", bus.ex_valid, 0);
    check_eq("mrst_memtoreg", bus.ex_memtoreg, 0);
    check_eq("mrst_alu_f", bus.alu_f, F_AND);
    check_eq("mrst_cnt", bus.bubble_cnt, 0);
    check_eq("mrst_stall", bus.stall_id, 0);
    #5;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
